data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 256, SHALL set the byte-array size; legal values are powers of two from 4 to 65536.
REQ-002 Parameter WAIT_STATES, default 1, SHALL set the extra busy cycles per access; legal range is 0..7.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous assert, active-low, synchronously released.
REQ-005 MemRead  in  1  SHALL be the read request, held by the initiator until MemReady.
REQ-006 MemWrite  in  1  SHALL be the write request, held by the initiator until MemReady.
REQ-007 Address  in  16  SHALL be the byte address of the low byte.
REQ-008 WriteData  in  16  SHALL be the write word: [7:0] goes to Address, [15:8] to Address+1.
REQ-009 MemData  out  16  SHALL be the registered read word, held until the next successful read.
REQ-010 MemReady  out  1  SHALL be a one-cycle completion strobe.
REQ-011 MemErr  out  1  SHALL be an error flag, valid only while MemReady=1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-013 In IDLE, at a rising edge with MemRead|MemWrite=1, the block SHALL accept the request, latch Address/WriteData/MemRead/MemWrite, load wait counter with WAIT_STATES, and go to BUSY.
REQ-014 In BUSY, when the counter is nonzero it SHALL decrement; when it is 0 the block SHALL perform the access at that edge and go to RESP.
REQ-015 Latency: MemReady SHALL be high for exactly the one cycle that begins WAIT_STATES+1 edges after the accept edge.
REQ-016 RESP SHALL always return to IDLE, giving one IDLE cycle between back-to-back accesses.
REQ-017 Input changes after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-018 Reads SHALL set MemData={mem[A+1],mem[A]} (little-endian) at the edge entering RESP.
REQ-019 Writes SHALL commit both bytes at the edge entering RESP.
REQ-020 Error responses: an error SHALL give MemErr=1 with MemReady, leave storage unchanged and leave MemData unchanged.
REQ-021 Error conditions: MemRead&MemWrite both set at accept.
REQ-022 Error conditions: A+1, computed in 17 bits, >= DEPTH_BYTES; Address=0xFFFF therefore errors and SHALL NOT wrap to 0.
REQ-023 A successful access SHALL drive MemErr=0 in its RESP cycle, and MemErr SHALL be 0 outside RESP.

Reset
REQ-024 Reset SHALL force state=IDLE, counter=0, MemData=0x0000, MemReady=0 and MemErr=0.
REQ-025 Reset during BUSY or RESP SHALL drop the pending access, with no write committed and no MemReady issued.
REQ-026 Storage contents SHALL NOT be affected by reset; they are undefined until written.

Configuration
REQ-027 With MISALIGN_TRAP_EN defined, an accepted access with Address[0]=1 SHALL be an error response per REQ-020.
REQ-028 Without MISALIGN_TRAP_EN, odd addresses SHALL be legal and access bytes A and A+1 per REQ-018/REQ-019.

Structure
REQ-029 Package mem_pkg SHALL hold the FSM state enum (IDLE, BUSY, RESP) and the constants ADDR_W=16, DATA_W=16, BYTE_W=8.
REQ-030 Storage SHALL be one sub-module, data_mem_bytes: a DEPTH_BYTES x 8 array with two byte read ports and two byte write ports sharing one write enable.
REQ-031 The FSM, counter, error checks and output registers SHALL reside in data_mem_responder.

Verification
REQ-032 Basic write/read (WAIT_STATES=2): write 0xBEEF @0x0010, then read @0x0010 -> MemReady exactly 3 edges after each accept, one cycle wide, MemErr=0, MemData=0xBEEF.
REQ-033 Byte order (macro undefined): write 0x1234 @0x0020 and 0x5678 @0x0022, then read @0x0021 -> MemData=0x7812.
REQ-034 Misalignment trap (MISALIGN_TRAP_EN defined): read @0x0021 after a prior read of 0x1234 -> MemErr=1, MemData stays 0x1234.
REQ-035 Illegal requests: MemRead=MemWrite=1 @0x0010 -> MemErr=1, @0x0010 still 0xBEEF; read @0x00FF (DEPTH 256) -> MemErr=1; read @0xFFFF -> MemErr=1.
REQ-036 Reset mid-write: rst_n low during BUSY of a write 0xAAAA @0x0010 -> all outputs 0 immediately and no MemReady; a later read returns 0xBEEF.
REQ-037 Latched request (WAIT_STATES=0): change Address and WriteData during BUSY -> originally latched values used, MemReady one edge after accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // High byte sits at addr+1; the sum is formed one bit wider so 0xFFFF cannot wrap to 0.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       depth);
    logic [ADDR_W:0] hi_addr;
    hi_addr = {1'b0, addr} + 17'd1;
    return (hi_addr >= 17'(depth));
  endfunction

endpackage

// File: rtl/data_mem_bytes.sv
// Byte-wide storage: two combinational byte read ports, two byte write ports
// committed together under a single write enable. Contents are never reset.
module data_mem_bytes
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr0,
  input  logic [BYTE_W-1:0] wdata0,
  input  logic [AW-1:0]     waddr1,
  input  logic [BYTE_W-1:0] wdata1,
  input  logic [AW-1:0]     raddr0,
  output logic [BYTE_W-1:0] rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [BYTE_W-1:0] rdata1
);

  logic [BYTE_W-1:0] mem_r [DEPTH_BYTES];

  // Both bytes of a word land on the same edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr0] <= wdata0;
      mem_r[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem_r[raddr0];
  assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated 16-bit little-endian memory responder over a byte array.
// Optional feature: define MISALIGN_TRAP_EN to make odd-address accesses error responses.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] MemData,
  output logic              MemReady,
  output logic              MemErr
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  state_t              state_r;
  state_t              state_nx_s;
  logic [2:0]          cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                rd_r;
  logic                wr_r;
  logic [DATA_W-1:0]   data_r;
  logic                ready_r;
  logic                err_r;

  logic                req_s;
  logic                fire_s;
  logic                misalign_s;
  logic                err_s;
  logic                mem_we_s;
  logic [ADDR_W:0]     addr_hi_s;
  logic [BYTE_W-1:0]   rd_lo_s;
  logic [BYTE_W-1:0]   rd_hi_s;

  assign req_s     = MemRead | MemWrite;
  assign fire_s    = (state_r == BUSY) && (cnt_r == 3'd0);
  assign addr_hi_s = {1'b0, addr_r} + 17'd1;

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = addr_r[0];
`else
  assign misalign_s = 1'b0;
`endif

  // Error decision uses only the latched request, so later input changes cannot affect it.
  assign err_s    = (rd_r & wr_r) | addr_out_of_range(addr_r, DEPTH_BYTES) | misalign_s;
  assign mem_we_s = fire_s & wr_r & ~err_s;

  data_mem_bytes #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_bytes (
    .clk    (clk),
    .we     (mem_we_s),
    .waddr0 (addr_r[AW-1:0]),
    .wdata0 (wdata_r[BYTE_W-1:0]),
    .waddr1 (addr_hi_s[AW-1:0]),
    .wdata1 (wdata_r[DATA_W-1:BYTE_W]),
    .raddr0 (addr_r[AW-1:0]),
    .rdata0 (rd_lo_s),
    .raddr1 (addr_hi_s[AW-1:0]),
    .rdata1 (rd_hi_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: RESP always falls back to IDLE, forcing one idle cycle between accesses.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 3'd0) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = BUSY;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 3'd0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            cnt_r   <= WAIT_LOAD;
            addr_r  <= Address;
            wdata_r <= WriteData;
            rd_r    <= MemRead;
            wr_r    <= MemWrite;
          end
        end
        BUSY: begin
          if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

  // Response registers: strobe and error live only for the RESP cycle; read data is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= 16'h0000;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= fire_s;
      err_r   <= fire_s & err_s;
      if (fire_s & rd_r & ~err_s) begin
        data_r <= {rd_hi_s, rd_lo_s};
      end
    end
  end

  assign MemData  = data_r;
  assign MemReady = ready_r;
  assign MemErr   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench with a transaction-level model for data_mem_responder.
module tb_data_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [15:0] Address = 16'h0000, WriteData = 16'h0000;
  logic [15:0] MemData;
  logic        MemReady, MemErr;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [15:0] addr0 = 16'h0000, wd0 = 16'h0000;
  logic [15:0] data0;
  logic        rdy0, err0;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData),
    .MemData(MemData), .MemReady(MemReady), .MemErr(MemErr)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd0), .MemWrite(wr0),
    .Address(addr0), .WriteData(wd0),
    .MemData(data0), .MemReady(rdy0), .MemErr(err0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model: byte array plus the one outstanding response (cycle, error, data after it).
  logic [7:0]  mdl_mem [DEPTH];
  int          resp_cyc = -1;
  logic        resp_err = 1'b0;
  logic [15:0] resp_data = 16'h0000;
  logic [15:0] prev_data = 16'h0000;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic mdl_err(input logic rd, input logic wr, input logic [15:0] a);
    logic e;
    e = (rd && wr) || ((int'(a) + 1) >= DEPTH);
`ifdef MISALIGN_TRAP_EN
    if (a[0]) e = 1'b1;
`endif
    return e;
  endfunction

  logic        cmp_rdy, cmp_err;
  logic [15:0] cmp_data;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cmp_rdy  = (cyc == resp_cyc);
      cmp_err  = cmp_rdy ? resp_err : 1'b0;
      cmp_data = (cyc >= resp_cyc) ? resp_data : prev_data;
      check("cyc_ready", {15'd0, MemReady}, {15'd0, cmp_rdy});
      check("cyc_err",   {15'd0, MemErr},   {15'd0, cmp_err});
      check("cyc_data",  MemData, cmp_data);
    end
  end

  // Issue one access from IDLE, scramble address/data while busy, return response info.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, output logic got_err,
                           output logic [15:0] got_data, output int lat);
    logic e;
    int   ai;
    @(negedge clk);
    ai = int'(a);
    e  = mdl_err(rd, wr, a);
    prev_data = resp_data;
    if (!e && wr) begin
      mdl_mem[ai]     = wd[7:0];
      mdl_mem[ai + 1] = wd[15:8];
    end
    if (!e && rd) resp_data = {mdl_mem[ai + 1], mdl_mem[ai]};
    resp_err = e;
    resp_cyc = cyc + WS + 2;
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!MemReady) begin
        Address   = 16'($urandom);
        WriteData = 16'($urandom);
      end
    end while (!MemReady && lat < 16);
    check("handshake", {15'd0, MemReady}, 16'd1);
    got_err  = MemErr;
    got_data = MemData;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  logic        g_err;
  logic [15:0] g_data;
  int          g_lat;

  initial begin
    #1;
    check("rst_data",  MemData, 16'h0000);
    check("rst_ready", {15'd0, MemReady}, 16'd0);
    check("rst_err",   {15'd0, MemErr}, 16'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    for (int a = 0; a < DEPTH; a += 2)
      do_access(1'b0, 1'b1, 16'(a), 16'($urandom), g_err, g_data, g_lat);

    do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, g_err, g_data, g_lat);
    check("wr_lat", 16'(g_lat), 16'd4);
    check("wr_err", {15'd0, g_err}, 16'd0);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, g_err, g_data, g_lat);
    check("rd_lat",  16'(g_lat), 16'd4);
    check("rd_err",  {15'd0, g_err}, 16'd0);
    check("rd_beef", g_data, 16'hBEEF);
    @(negedge clk);
    check("ready_oneshot", {15'd0, MemReady}, 16'd0);

    do_access(1'b0, 1'b1, 16'h0020, 16'h1234, g_err, g_data, g_lat);
    do_access(1'b0, 1'b1, 16'h0022, 16'h5678, g_err, g_data, g_lat);
`ifdef MISALIGN_TRAP_EN
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, g_err, g_data, g_lat);
    check("rd_1234", g_data, 16'h1234);
    do_access(1'b1, 1'b0, 16'h0021, 16'h0000, g_err, g_data, g_lat);
    check("misalign_err",  {15'd0, g_err}, 16'd1);
    check("misalign_data", g_data, 16'h1234);
`else
    do_access(1'b1, 1'b0, 16'h0021, 16'h0000, g_err, g_data, g_lat);
    check("odd_err",  {15'd0, g_err}, 16'd0);
    check("odd_data", g_data, 16'h7812);
`endif

    do_access(1'b1, 1'b1, 16'h0010, 16'h5555, g_err, g_data, g_lat);
    check("both_err", {15'd0, g_err}, 16'd1);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, g_err, g_data, g_lat);
    check("both_keep", g_data, 16'hBEEF);
    do_access(1'b1, 1'b0, 16'h00FF, 16'h0000, g_err, g_data, g_lat);
    check("top_err", {15'd0, g_err}, 16'd1);
    do_access(1'b1, 1'b0, 16'hFFFF, 16'h0000, g_err, g_data, g_lat);
    check("wrap_err", {15'd0, g_err}, 16'd1);

    // Reset while a write is still in its wait states.
    chk_en = 1'b0;
    @(negedge clk);
    MemWrite = 1'b1; Address = 16'h0010; WriteData = 16'hAAAA;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data",  MemData, 16'h0000);
    check("mid_rst_ready", {15'd0, MemReady}, 16'd0);
    check("mid_rst_err",   {15'd0, MemErr}, 16'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_noready", {15'd0, MemReady}, 16'd0);
    end
    MemWrite  = 1'b0;
    rst_n     = 1'b1;
    resp_data = 16'h0000;
    prev_data = 16'h0000;
    resp_cyc  = -1;
    chk_en    = 1'b1;
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, g_err, g_data, g_lat);
    check("post_rst_beef", g_data, 16'hBEEF);

    for (int i = 0; i < 300; i++) begin
      int unsigned kind;
      logic [15:0] a;
      logic        rd, wr, e;
      kind = $urandom_range(0, 9);
      rd = (kind <= 3) || (kind >= 8);
      wr = (kind >= 4) && (kind <= 8);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(250, 65535));
      else                            a = 16'($urandom_range(0, 255));
      e = mdl_err(rd, wr, a);
      do_access(rd, wr, a, 16'($urandom), g_err, g_data, g_lat);
      check("rand_err", {15'd0, g_err}, {15'd0, e});
    end

    // Zero-wait-state instance: inputs changed during BUSY must be ignored.
    @(negedge clk);
    wr0 = 1'b1; addr0 = 16'h0040; wd0 = 16'h4321;
    @(negedge clk);
    check("ws0_busy", {15'd0, rdy0}, 16'd0);
    addr0 = 16'h0050; wd0 = 16'hFFFF;
    @(negedge clk);
    check("ws0_wr_lat", {15'd0, rdy0}, 16'd1);
    check("ws0_wr_err", {15'd0, err0}, 16'd0);
    wr0 = 1'b0;
    @(negedge clk);
    rd0 = 1'b1; addr0 = 16'h0040;
    @(negedge clk);
    check("ws0_busy_rd", {15'd0, rdy0}, 16'd0);
    addr0 = 16'h0050;
    @(negedge clk);
    check("ws0_rd_lat",  {15'd0, rdy0}, 16'd1);
    check("ws0_rd_data", data0, 16'h4321);
    rd0 = 1'b0;
    @(negedge clk);
    check("ws0_oneshot", {15'd0, rdy0}, 16'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
